ram_sp_arbiter: RTL

- Shares one single-port, async-read, write-first RAM between two requesters, A and B (for example the UART RX buffer writer and the host-side reader/writer).
- Grants at most one access per clock, using round-robin priority plus optional bounded burst locking.
- Drives the RAM port combinationally from the granted requester and returns read data registered, one cycle later.

---
 rtl/ram_sp_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_sp_arbiter.sv
// Two-port round-robin arbiter with bounded burst locking in front of one single-port async-read RAM.
// Define RAM_SP_ARBITER_STATS_EN to add grant and conflict counters.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_lock,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_lock,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef RAM_SP_ARBITER_STATS_EN
  ,
  output logic [15:0]           a_gnt_cnt,
  output logic [15:0]           b_gnt_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

  localparam logic [7:0] MaxBurstW = 8'(MAX_BURST);

  owner_e                owner_q, owner_d;
  logic                  last_q, last_d;
  logic [7:0]            bcnt_q, bcnt_d;
  logic [7:0]            bcnt_inc;
  logic                  burst_open;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  assign burst_open = (bcnt_q < MaxBurstW);
  assign bcnt_inc   = (bcnt_q == 8'hFF) ? 8'hFF : bcnt_q + 8'd1;

  // The lock holder keeps the port until it stops asking or its burst runs out under contention.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (owner_q == OWN_A && a_req && (!b_req || burst_open)) begin
        a_gnt = 1'b1;
      end else if (owner_q == OWN_B && b_req && (!a_req || burst_open)) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        a_gnt = last_q;
        b_gnt = !last_q;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  always_comb begin
    last_d  = last_q;
    owner_d = OWN_NONE;
    bcnt_d  = 8'd0;
    if (a_gnt) begin
      last_d = 1'b0;
      if (a_lock) begin
        owner_d = OWN_A;
        bcnt_d  = (owner_q == OWN_A) ? bcnt_inc : 8'd1;
      end
    end else if (b_gnt) begin
      last_d = 1'b1;
      if (b_lock) begin
        owner_d = OWN_B;
        bcnt_d  = (owner_q == OWN_B) ? bcnt_inc : 8'd1;
      end
    end
  end

  assign ram_we   = (a_gnt && a_we) || (b_gnt && b_we);
  assign ram_addr = b_gnt ? b_addr  : a_addr;
  assign ram_din  = b_gnt ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      last_q     <= 1'b1;
      bcnt_q     <= 8'd0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
      a_rvalid_q <= a_gnt && !a_we;
      b_rvalid_q <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata_q <= ram_dout;
      if (b_gnt && !b_we) b_rdata_q <= ram_dout;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

`ifdef RAM_SP_ARBITER_STATS_EN
  logic [15:0] a_gnt_cnt_q, b_gnt_cnt_q, conflict_cnt_q;

  // Grant counters wrap; the conflict counter sticks at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_gnt_cnt_q    <= 16'd0;
      b_gnt_cnt_q    <= 16'd0;
      conflict_cnt_q <= 16'd0;
    end else begin
      if (a_gnt) a_gnt_cnt_q <= a_gnt_cnt_q + 16'd1;
      if (b_gnt) b_gnt_cnt_q <= b_gnt_cnt_q + 16'd1;
      if (a_req && b_req && conflict_cnt_q != 16'hFFFF) conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign a_gnt_cnt    = a_gnt_cnt_q;
  assign b_gnt_cnt    = b_gnt_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
